// File: rtl/ahfp_mod_pi_arb.sv
// ---------------------------------------------------------------------------
// ahfp_mod_pi_arb
//
// Round-robin front end that shares one fixed-latency mod-pi datapath among
// NREQ requesters. Each accepted operand is sent out on mp_data, and a tag
// holding {valid, id} travels alongside it through a PIPE_LAT-deep shift
// register. When the tag leaves the shift register, mp_result is captured
// together with the tag id into a first-word-fall-through result FIFO.
// Grants are issued only when a FIFO slot is guaranteed for the result, so
// the FIFO can never overflow and the datapath never has to stall.
//
// Ports
//   clk        in   single clock, rising edge
//   reset      in   synchronous, active-high reset
//   req_valid  in   [NREQ]     per-requester operand valid
//   req_data   in   [32*NREQ]  operands, requester i in bits [32i+31:32i]
//   req_ready  out  [NREQ]     per-requester grant (one-hot or zero)
//   mp_data    out  [32]       operand to the shared datapath (0 when idle)
//   mp_result  in   [32]       datapath result, PIPE_LAT cycles after mp_data
//   res_valid  out             result FIFO head valid
//   res_data   out  [32]       head result (0 when empty)
//   res_id     out  [IDW]      requester that issued the head result
//   res_ready  in              consumer accepts the head entry
//   busy       out             operations in flight or FIFO non-empty
// ---------------------------------------------------------------------------
module ahfp_mod_pi_arb #(
  parameter int NREQ       = 4,
  parameter int IDW        = 2,
  parameter int PIPE_LAT   = 14,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [31:0]          mp_data,
  input  logic [31:0]          mp_result,
  output logic                 res_valid,
  output logic [31:0]          res_data,
  output logic [IDW-1:0]       res_id,
  input  logic                 res_ready,
  output logic                 busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  // One spare bit so the occupancy sum can be compared against FIFO_DEPTH.
  localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;

  // Arbitration state and credit counters
  logic [IDW-1:0]      r_lastGrant;
  logic [CW-1:0]       r_inflight;
  logic [CW-1:0]       r_fifoCount;

  // Tag pipeline running in parallel with the datapath
  logic [PIPE_LAT-1:0] r_tagValid;
  logic [IDW-1:0]      r_tagId [PIPE_LAT];

  // Result FIFO storage: {id, data}
  logic [IDW+31:0]     r_mem [FIFO_DEPTH];
  logic [PW-1:0]       r_wrPtr;
  logic [PW-1:0]       r_rdPtr;

  logic                w_found;
  logic [IDW-1:0]      w_winner;
  logic [CW-1:0]       w_occupancy;
  logic                w_credit;
  logic                w_accept;
  logic                w_push;
  logic                w_pop;
  logic                w_notEmpty;

  // Requester index reached by stepping 'off' places past 'base', wrapping at NREQ.
  function automatic logic [IDW-1:0] rrIndex(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return s[IDW-1:0];
  endfunction

  // Round-robin search: start just after the last winner and take the first
  // requester presenting valid. The last winner itself is checked last.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!w_found && req_valid[rrIndex(r_lastGrant, k)]) begin
        w_found  = 1'b1;
        w_winner = rrIndex(r_lastGrant, k);
      end
    end
  end

  // Credit check uses registered counts only, so a pop this cycle frees a
  // slot starting next cycle and req_ready never depends on res_ready.
  assign w_occupancy = r_inflight + r_fifoCount;
  assign w_credit    = w_occupancy < CW'(FIFO_DEPTH);
  assign w_accept    = !reset && w_found && w_credit;

  assign req_ready = w_accept ? (NREQ'(1) << w_winner) : '0;
  assign mp_data   = w_accept ? req_data[int'(w_winner)*32 +: 32] : '0;

  // A tag leaving the last stage means mp_result holds that operand's result.
  assign w_push     = r_tagValid[PIPE_LAT-1];
  assign w_notEmpty = r_fifoCount != '0;
  assign w_pop      = w_notEmpty && res_ready;

  // Tag valid bits are cleared by reset so in-flight results are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tagValid <= '0;
    end else begin
      r_tagValid[0] <= w_accept;
      for (int i = 1; i < PIPE_LAT; i++) begin
        r_tagValid[i] <= r_tagValid[i-1];
      end
    end
  end

  // Tag ids are only meaningful where the matching valid bit is set.
  always_ff @(posedge clk) begin
    r_tagId[0] <= w_winner;
    for (int i = 1; i < PIPE_LAT; i++) begin
      r_tagId[i] <= r_tagId[i-1];
    end
  end

  // Counters, pointers and round-robin pointer. last_grant resets to the
  // highest index so requester 0 is first in line after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lastGrant <= IDW'(NREQ - 1);
      r_inflight  <= '0;
      r_fifoCount <= '0;
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
    end else begin
      if (w_accept) r_lastGrant <= w_winner;
      r_inflight  <= r_inflight + CW'(w_accept) - CW'(w_push);
      r_fifoCount <= r_fifoCount + CW'(w_push) - CW'(w_pop);
      r_wrPtr     <= r_wrPtr + PW'(w_push);
      r_rdPtr     <= r_rdPtr + PW'(w_pop);
    end
  end

  // FIFO storage needs no reset; the count decides what is visible.
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_mem[r_wrPtr] <= {r_tagId[PIPE_LAT-1], mp_result};
    end
  end

  assign res_valid = !reset && w_notEmpty;
  assign res_data  = res_valid ? r_mem[r_rdPtr][31:0] : '0;
  assign res_id    = res_valid ? r_mem[r_rdPtr][IDW+31:32] : '0;
  assign busy      = !reset && ((r_inflight != '0) || w_notEmpty);

endmodule

// File: tb/tb_ahfp_mod_pi_arb.sv
// ---------------------------------------------------------------------------
// tb_ahfp_mod_pi_arb
//
// Self-checking bench for ahfp_mod_pi_arb. The datapath is modelled as a
// pure PIPE_LAT-cycle delay of mp_data. An arbitration model samples on the
// falling edge, predicts grants from the round-robin rule and a credit
// count, and pushes each expected result into a scoreboard queue. A result
// monitor pops and compares whenever the DUT presents a result.
// ---------------------------------------------------------------------------
module tb_ahfp_mod_pi_arb;

  localparam int NREQ       = 4;
  localparam int IDW        = 2;
  localparam int PIPE_LAT   = 14;
  localparam int FIFO_DEPTH = 16;

  typedef struct {
    logic [31:0]    data;
    logic [IDW-1:0] id;
    int             rdy;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [32*NREQ-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic [31:0]          mp_data;
  logic [31:0]          mp_result;
  logic                 res_valid;
  logic [31:0]          res_data;
  logic [IDW-1:0]       res_id;
  logic                 res_ready;
  logic                 busy;

  int   cyc         = 0;
  int   checkCount  = 0;
  int   errorCount  = 0;
  int   dutAccepts  = 0;

  exp_t expQ[$];
  int   exitQ[$];
  int   mFifo = 0;
  int   mLast = NREQ - 1;

  logic [31:0] delayLine [PIPE_LAT];

  ahfp_mod_pi_arb #(
    .NREQ(NREQ), .IDW(IDW), .PIPE_LAT(PIPE_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .mp_data(mp_data), .mp_result(mp_result),
    .res_valid(res_valid), .res_data(res_data), .res_id(res_id),
    .res_ready(res_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Cycle index shared by the model and the monitor.
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath stand-in: result equals operand, PIPE_LAT cycles later.
  always @(posedge clk) begin
    delayLine[0] <= mp_data;
    for (int i = 1; i < PIPE_LAT; i++) delayLine[i] <= delayLine[i-1];
  end
  assign mp_result = delayLine[PIPE_LAT-1];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Arbitration model: predicts grants and issues expected results.
  always @(negedge clk) begin : arbModel
    int occ;
    int win;
    logic [NREQ-1:0] expReady;
    logic [31:0]     expMp;
    logic            doPush;
    logic            doPop;
    if (reset) begin
      checkOutput("reset_req_ready", 32'(req_ready), 32'h0);
      checkOutput("reset_mp_data", mp_data, 32'h0);
      checkOutput("reset_busy", 32'(busy), 32'h0);
      exitQ.delete();
      mFifo = 0;
      mLast = NREQ - 1;
    end else begin
      occ = exitQ.size() + mFifo;
      win = -1;
      for (int k = 1; k <= NREQ; k++) begin
        if (win < 0 && req_valid[(mLast + k) % NREQ]) win = (mLast + k) % NREQ;
      end
      expReady = (win >= 0 && occ < FIFO_DEPTH) ? (NREQ'(1) << win) : '0;
      expMp    = (expReady != '0) ? req_data[32*win +: 32] : 32'h0;
      checkOutput("req_ready", 32'(req_ready), 32'(expReady));
      checkOutput("mp_data", mp_data, expMp);
      checkOutput("busy", 32'(busy), 32'(occ != 0));
      if (req_ready != '0) begin
        dutAccepts++;
        checkOutput("grant_when_full", 32'(occ < FIFO_DEPTH), 32'h1);
      end
      doPop  = (mFifo > 0) && res_ready;
      doPush = (exitQ.size() > 0) && (exitQ[0] == cyc);
      if (doPush) void'(exitQ.pop_front());
      mFifo = mFifo + int'(doPush) - int'(doPop);
      if (expReady != '0) begin
        exitQ.push_back(cyc + PIPE_LAT);
        expQ.push_back('{data: req_data[32*win +: 32], id: IDW'(win), rdy: cyc + PIPE_LAT + 1});
        mLast = win;
      end
    end
  end

  // Result monitor: compares the FIFO head against the scoreboard.
  initial begin : resMonitor
    logic expValid;
    forever begin
      @(posedge clk);
      #2;
      if (reset) begin
        checkOutput("reset_res_valid", 32'(res_valid), 32'h0);
        checkOutput("reset_res_data", res_data, 32'h0);
        checkOutput("reset_res_id", 32'(res_id), 32'h0);
        expQ.delete();
      end else begin
        expValid = (expQ.size() > 0) && (expQ[0].rdy <= cyc);
        checkOutput("res_valid", 32'(res_valid), 32'(expValid));
        if (expValid) begin
          checkOutput("res_data", res_data, expQ[0].data);
          checkOutput("res_id", 32'(res_id), 32'(expQ[0].id));
          if (res_valid && res_ready) void'(expQ.pop_front());
        end else begin
          checkOutput("res_data_empty", res_data, 32'h0);
          checkOutput("res_id_empty", 32'(res_id), 32'h0);
        end
      end
    end
  end

  // Drives one input pattern for n cycles with fresh random operands.
  task automatic applyStimulus(input logic [NREQ-1:0] v, input logic rr, input logic rst, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      reset     = rst;
      req_valid = v;
      res_ready = rr;
      for (int j = 0; j < NREQ; j++) req_data[32*j +: 32] = $urandom;
    end
  endtask

  initial begin : driver
    int snap;
    int pct;
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    res_ready = 1'b0;
    applyStimulus('0, 1'b0, 1'b1, 3);

    // Single operation from requester 0
    @(posedge clk);
    #1;
    reset        = 1'b0;
    req_valid    = 4'b0001;
    req_data     = '0;
    req_data[31:0] = 32'h3F800000;
    res_ready    = 1'b1;
    applyStimulus('0, 1'b1, 1'b0, 20);

    // Fairness with all requesters valid
    applyStimulus('1, 1'b1, 1'b0, 40);
    applyStimulus('0, 1'b1, 1'b0, 20);

    // Backpressure: FIFO fills, then single pops
    snap = dutAccepts;
    applyStimulus('1, 1'b0, 1'b0, 40);
    checkOutput("bp_accepts", 32'(dutAccepts - snap), 32'd16);
    applyStimulus('1, 1'b1, 1'b0, 1);
    snap = dutAccepts;
    applyStimulus('1, 1'b0, 1'b0, 14);
    checkOutput("pop_regrant", 32'(dutAccepts - snap), 32'd1);
    // Push and pop in the same cycle at the full boundary
    applyStimulus('1, 1'b1, 1'b0, 1);
    snap = dutAccepts;
    applyStimulus('1, 1'b0, 1'b0, 5);
    checkOutput("full_boundary_regrant", 32'(dutAccepts - snap), 32'd1);
    applyStimulus('0, 1'b1, 1'b0, 40);

    // Skip over idle requesters
    applyStimulus('0, 1'b1, 1'b1, 2);
    applyStimulus(4'b0001, 1'b1, 1'b0, 1);
    applyStimulus(4'b1010, 1'b1, 1'b0, 3);
    applyStimulus('0, 1'b1, 1'b0, 20);

    // Reset with operations in flight
    applyStimulus('1, 1'b1, 1'b0, 3);
    applyStimulus('0, 1'b1, 1'b0, 2);
    applyStimulus('0, 1'b1, 1'b1, 2);
    applyStimulus('0, 1'b1, 1'b0, 30);

    // Randomised traffic with varying consumer pressure
    for (int seg = 0; seg < 8; seg++) begin
      pct = (seg % 3 == 0) ? 90 : ((seg % 3 == 1) ? 10 : 50);
      for (int i = 0; i < 60; i++) begin
        applyStimulus(NREQ'($urandom), ($urandom_range(0, 99) < pct),
                      ($urandom_range(0, 299) == 0), 1);
      end
    end
    applyStimulus('0, 1'b1, 1'b0, 40);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
